// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial unsigned adder, one full-adder cell shared across
//                WIDTH bit positions, LSB first, with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam [c_cnt_w-1:0]   c_last  = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_ra;
    logic [WIDTH-1:0]   r_rb;
    logic [WIDTH-1:0]   r_sum;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_carry;
    logic               r_cout;

    // Full adder built from two half adders; their carries never both assert.
    logic w_ha0_s;
    logic w_ha0_c;
    logic w_ha1_c;
    logic w_s;
    logic w_carry_next;

    assign w_ha0_s      = r_ra[0] ^ r_rb[0];
    assign w_ha0_c      = r_ra[0] & r_rb[0];
    assign w_s          = w_ha0_s ^ r_carry;
    assign w_ha1_c      = w_ha0_s & r_carry;
    assign w_carry_next = w_ha0_c | w_ha1_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SHIFT;
            S_SHIFT: if (r_cnt == c_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ra    <= '0;
            r_rb    <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ra    <= a;
                        r_rb    <= b;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_carry <= 1'b0;
                        r_cout  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_carry_next;
                    r_ra    <= {1'b0, r_ra[WIDTH-1:1]};
                    r_rb    <= {1'b0, r_rb[WIDTH-1:1]};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_cout <= w_carry_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs decode straight from the state register.
    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Directed self-checking bench for serial_adder (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int n_checks;
    int n_errors;
    int n_done;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One start pulse; checks busy window, done timing and the result.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] es, input logic ec);
        @(negedge clk);
        a     = ta;
        b     = tb_;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        check("accept_busy_done", {30'd0, busy, done}, 32'b10);
        check("accept_sum_clear", {23'd0, cout, sum}, 32'd0);
        for (int i = 1; i < 8; i++) begin
            step();
            check("shift_busy_done", {30'd0, busy, done}, 32'b10);
        end
        step();
        check("done_busy_done", {30'd0, busy, done}, 32'b01);
        check("done_sum", {24'd0, sum}, {24'd0, es});
        check("done_cout", {31'd0, cout}, {31'd0, ec});
        step();
        check("post_busy_done", {30'd0, busy, done}, 32'b00);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        #1;
        check("reset_busy_done", {30'd0, busy, done}, 32'b00);
        check("reset_sum_cout", {23'd0, cout, sum}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic add, then sum/cout must hold while idle
        run_op(8'h3C, 8'h05, 8'h41, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("idle_hold", {23'd0, cout, sum}, 32'h041);
        end

        // Carry out and full ripple
        run_op(8'hFF, 8'h01, 8'h00, 1'b1);
        run_op(8'hFF, 8'hFF, 8'hFE, 1'b1);
        step();
        check("idle_hold_fe", {23'd0, cout, sum}, 32'h1FE);

        // Start during SHIFT must be ignored and not queued
        @(negedge clk);
        a = 8'h3C; b = 8'h05; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        a = 8'h01; b = 8'h01; start = 1'b1;
        step();
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (done) begin
                n_done++;
                check("ignored_start_sum", {23'd0, cout, sum}, 32'h041);
            end
        end
        check("ignored_start_done_count", n_done, 1);
        check("ignored_start_idle", {30'd0, busy, done}, 32'b00);

        // Async reset in the middle of SHIFT
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("pre_reset_partial_sum", {23'd0, cout, sum}, 32'h0C0);
        #2 rst = 1'b1;
        #1;
        check("async_reset_busy_done", {30'd0, busy, done}, 32'b00);
        check("async_reset_sum_cout", {23'd0, cout, sum}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done || busy) n_done++;
        end
        check("no_done_after_reset", n_done, 0);
        run_op(8'h10, 8'h20, 8'h30, 1'b0);

        // Start held high: back-to-back ops every 10 cycles
        @(negedge clk);
        a = 8'h80; b = 8'h80; start = 1'b1;
        n_done = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            if (done) begin
                n_done++;
                check("b2b_done_cycle", k % 10, 8);
                check("b2b_sum_cout", {23'd0, cout, sum}, 32'h100);
            end
            if (k == 9 || k == 19) begin
                check("b2b_hold_after_done", {29'd0, busy, done, cout}, 32'b001);
            end
            if (k == 10 || k == 20) begin
                check("b2b_reaccept", {29'd0, busy, done, cout}, 32'b100);
            end
        end
        start = 1'b0;
        check("b2b_done_count", n_done, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
